encoder_8to3: RTL and testbench

- Registered 8-to-3 binary encoder with enable, valid flag and multi-hot detection.
- Converts an 8-bit request vector (nominally one-hot) into the 3-bit index of the active line.
- Sits behind request/interrupt collection logic and feeds index-based muxing or arbitration downstream.
- Outputs are registered: one clock of latency.

---
 rtl/encoder_8to3_if.sv | 10 +
 rtl/encoder_8to3.sv | 39 +++
 tb/tb_encoder_8to3.sv | 126 ++++++++++++
 3 files changed

// File: rtl/encoder_8to3_if.sv
// encoder_8to3_if: request/index bundle between the request collector (master) and the encoder (slave)
interface encoder_8to3_if;
  logic [7:0] d;
  logic       en;
  logic [2:0] y;
  logic       valid;
  logic       multi_hot;
  modport master (output d, en, input y, valid, multi_hot);
  modport slave (input d, en, output y, valid, multi_hot);
endinterface

// File: rtl/encoder_8to3.sv
// encoder_8to3: registered 8-to-3 priority encoder with valid flag; multi-hot detection is built only when ENC_MULTIHOT_DET_EN is defined
module encoder_8to3 #(
  parameter bit LSB_PRIORITY = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  encoder_8to3_if.slave  bus
);
  logic [2:0] idx;
  logic       hit;
  logic       multi;
  // ascending scan: the last set bit wins for MSB priority, the first one for LSB priority
  always_comb begin
    idx = 3'd0;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.d[i] && (!LSB_PRIORITY || !hit)) begin
        idx = 3'(i);
        hit = 1'b1;
      end
    end
  end
`ifdef ENC_MULTIHOT_DET_EN
  assign multi = |(bus.d & 8'(bus.d - 8'd1));
`else
  assign multi = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y         <= 3'd0;
      bus.valid     <= 1'b0;
      bus.multi_hot <= 1'b0;
    end else begin
      bus.y         <= bus.en ? idx : 3'd0;
      bus.valid     <= bus.en & hit;
      bus.multi_hot <= bus.en & multi;
    end
  end
endmodule

// File: tb/tb_encoder_8to3.sv
// tb_encoder_8to3: table, corner-sequence and random checks of both priority variants against an arithmetic model
module tb_encoder_8to3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
`ifdef ENC_MULTIHOT_DET_EN
  localparam bit MH = 1'b1;
`else
  localparam bit MH = 1'b0;
`endif
  encoder_8to3_if b0 ();
  encoder_8to3_if b1 ();
  encoder_8to3 #(.LSB_PRIORITY(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  encoder_8to3 #(.LSB_PRIORITY(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  always #5 clk = ~clk;

  typedef struct {
    bit         en;
    logic [7:0] d;
    int         y_hi;
    int         y_lo;
    bit         v;
    bit         m;
  } vec_t;
  vec_t tbl[$];

  function automatic int top_bit(logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) if (int'(v) >= (1 << k)) n = k;
    return n;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit en, logic [7:0] d);
    b0.en = en; b0.d = d;
    b1.en = en; b1.d = d;
  endtask

  task automatic step(bit en, logic [7:0] d);
    @(negedge clk);
    drive(en, d);
    @(negedge clk);
  endtask

  task automatic check_all(string tag, int y_hi, int y_lo, bit v, bit m);
    check({tag, ".y_msb"}, int'(b0.y), y_hi);
    check({tag, ".valid_msb"}, int'(b0.valid), int'(v));
    check({tag, ".mh_msb"}, int'(b0.multi_hot), int'(m));
    check({tag, ".y_lsb"}, int'(b1.y), y_lo);
    check({tag, ".valid_lsb"}, int'(b1.valid), int'(v));
    check({tag, ".mh_lsb"}, int'(b1.multi_hot), int'(m));
  endtask

  task automatic model_check(string tag, bit en, logic [7:0] d);
    bit v = en && d != 8'd0;
    logic [7:0] low = d & 8'(~d + 8'd1);
    check_all(tag, v ? top_bit(d) : 0, v ? top_bit(low) : 0, v, MH && en && $countones(d) > 1);
  endtask

  initial begin
    drive(1'b1, 8'hFF);
    repeat (3) begin
      @(negedge clk);
      check_all("reset_hold", 0, 0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h20);
    @(negedge clk);
    check_all("release", 5, 5, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all("async_clear", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h12);
    @(negedge clk);
    check_all("re_encode", 4, 1, 1'b1, MH);

    for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 8'(1 << i), 0, 0, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 8'(1 << i), i, i, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 0, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h92, 7, 1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 8'hFF, 7, 0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 8'h81, 7, 0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 8'h0C, 3, 2, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 8'hFF, 0, 0, 1'b0, 1'b0});
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].d);
      check_all($sformatf("tbl%0d", i), tbl[i].y_hi, tbl[i].y_lo, tbl[i].v, MH && tbl[i].m);
    end

    step(1'b1, 8'h20);
    check_all("en_on", 5, 5, 1'b1, 1'b0);
    step(1'b0, 8'h20);
    check_all("en_off", 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      bit en;
      en = $urandom_range(3) != 0;
      case ($urandom_range(3))
        0: d = 8'(1 << $urandom_range(7));
        1: d = 8'h00;
        default: d = 8'($urandom);
      endcase
      @(negedge clk);
      drive(en, d);
      #2 drive(~en, ~d);
      #2 drive(en, d);
      @(negedge clk);
      model_check($sformatf("rnd%0d", i), en, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
